gate_check_seq: RTL and testbench
=================================

Name: gate_check_seq

Overview:
- Sequencer that exhaustively exercises a shared 2^N_IN-row combinational gate under test, such as the NOR-built OR cell, against a golden model.
- Drives each input vector and waits a programmable settle time.
- Compares the DUT output with the reference output and accumulates the mismatch count and the first failing vector.
- Sits between a bench or top-level controller (start/done handshake) and one gate-under-test/golden pair that share the same input bus.

Parameters:
- N_IN, 2, number of gate inputs; the vector bus is N_IN bits wide and 2^N_IN vectors are applied.
- SETTLE, 1, cycles each vector is held before comparison; legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- vec  output  N_IN  input vector driven to both the DUT and the golden model; registered.
- dut_s  input  1  gate-under-test output.
- ref_s  input  1  golden-model output.
- busy  output  1  high in WAIT and CMP.
- done  output  1  one-cycle pulse at run completion.
- pass  output  1  err_count==0 for the last completed run; held until the next start.
- err_count  output  N_IN+1  number of mismatching vectors, range 0..2^N_IN.
- first_err_vec  output  N_IN  first vector that mismatched.
- first_err_valid  output  1  first_err_vec is meaningful.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, vec=0, state IDLE, settle counter 0. Reset takes effect immediately, including mid-run; there is no done pulse and results are lost.
- FSM states: IDLE, WAIT, CMP, DONE.
- IDLE:
  - start=1 and abort=0 → vec<=0, cnt<=0, err_count<=0, first_err_valid<=0, pass<=0, next state WAIT.
  - Otherwise stay in IDLE with results held.
- WAIT: cnt==SETTLE-1 → CMP; otherwise cnt++.
- CMP:
  - Sample dut_s and ref_s this cycle.
  - On mismatch: err_count++. If first_err_valid==0, capture first_err_vec<=vec and set first_err_valid<=1.
  - If vec is all-ones → DONE. Otherwise vec++, cnt<=0, next state WAIT.
- DONE:
  - done=1 for exactly this cycle.
  - pass<=(final err_count==0), using the count that includes the last CMP.
  - Next state IDLE; vec holds its last value.
- Latency: done is high in cycle 2^N_IN*(SETTLE+1)+1 counted after the start-sampling edge. Defaults give 9.
- start while busy or in DONE: ignored; there is no queueing.
- abort in WAIT or CMP:
  - Next state IDLE and busy drops the next cycle.
  - No done pulse; pass stays 0.
  - err_count and first_err_* keep their partial values.
  - Any compare in that CMP cycle is discarded.
- abort in DONE: ignored; the run has already completed.
- Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
- vec wrap: never wraps within a run; the all-ones vector terminates the run.
- err_count: cannot overflow because its width is N_IN+1. No saturation logic is present.
- X on dut_s or ref_s counts as a mismatch, using the case-inequality comparison.

Decomposition:
- Shared package gate_check_pkg:
  - state enum (IDLE, WAIT, CMP, DONE) with 2-bit encoding.
  - SETTLE_MAX=15 constant.
  - Helper function for the count width, N_IN+1.
- Sub-module gate_check_timer: the settle counter. Ports: clk, rst_n, clr, en, expire. expire is high when cnt==SETTLE-1. The rest stays in gate_check_seq.

Test Plan:
- Basic pass: N_IN=2, SETTLE=1, DUT=NOR-based OR, ref=behavioural OR, start pulse at cycle 0 → vec sequence 00,01,10,11 with each held 2 cycles; done in cycle 9; pass=1; err_count=0; first_err_valid=0.
- Stuck-at-0 DUT (dut_s=0), ref=OR → err_count=3; first_err_vec=01; first_err_valid=1; pass=0; done in cycle 9.
- Inverted DUT (NOR), ref=OR → err_count=4; first_err_vec=00; pass=0.
- Abort and busy behaviour:
  - Abort asserted in cycle 4 (CMP of vec 01) with DUT stuck-at-0 → busy=0 from cycle 5; no done pulse; err_count=0 (the CMP-cycle compare is discarded); pass=0.
  - start re-pulsed while busy → ignored; the run completes on the original schedule.
- Reset mid-run: rst_n low asynchronously in cycle 5 → all outputs 0 immediately with no clock edge needed; after release, a new start runs a full clean sequence.
- SETTLE=3, all-match → each vector held 4 cycles; done in cycle 17; pass=1. Simultaneous start and abort in IDLE → no run starts and busy stays 0.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate check sequencer.
//   state_t     : sequencer FSM states, 2-bit encoding
//   SETTLE_MAX  : largest legal settle time in cycles
//   cnt_width() : width of the mismatch counter for a given input count
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SETTLE_MAX = 15;

    // One extra bit so a run where every vector fails (2^n_in) still fits.
    function automatic int cnt_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/gate_check_timer.sv
// Settle counter for the gate check sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (has priority over en)
//   en         : advance the count by one
//   expire     : count has reached SETTLE-1
module gate_check_timer
    import gate_check_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(SETTLE_MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expire = (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_check_seq.sv
// Exhaustive sequencer for a combinational gate under test.
// Walks vec from 0 to all-ones, holds each vector SETTLE cycles plus one
// compare cycle, and compares the gate output against a golden model.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : run control (start sampled in IDLE, abort in WAIT/CMP)
//   vec               : registered vector shared by DUT and golden model
//   dut_s, ref_s      : gate-under-test and golden outputs
//   busy, done        : run in progress / one-cycle completion pulse
//   pass              : last completed run had no mismatches
//   err_count         : mismatching vectors in the current/last run
//   first_err_vec/_valid : first mismatching vector and its qualifier
module gate_check_seq
    import gate_check_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    output logic [N_IN-1:0]              vec,
    input  logic                         dut_s,
    input  logic                         ref_s,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [cnt_width(N_IN)-1:0]   err_count,
    output logic [N_IN-1:0]              first_err_vec,
    output logic                         first_err_valid
);

    state_t state, state_nxt;
    logic   expire;
    logic   tmr_clr, tmr_en;
    logic   mismatch;
    logic   last_vec;
    logic   go;

    // Case inequality so an X/Z on either side is reported as a failure.
    assign mismatch = (dut_s !== ref_s);
    assign last_vec = &vec;
    assign go       = start && !abort;

    gate_check_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = WAIT;
            WAIT: begin
                if (abort)       state_nxt = IDLE;
                else if (expire) state_nxt = CMP;
            end
            CMP: begin
                if (abort)         state_nxt = IDLE;
                else if (last_vec) state_nxt = DONE;
                else               state_nxt = WAIT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; the counter only runs in WAIT and sits at 0 everywhere else,
    // so every WAIT entry starts from a clean count.
    always_comb begin
        busy    = (state == WAIT) || (state == CMP);
        done    = (state == DONE);
        tmr_clr = (state != WAIT);
        tmr_en  = (state == WAIT) && !expire;
    end

    // Result and vector datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec             <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        vec             <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        pass            <= 1'b0;
                    end
                end
                CMP: begin
                    // An abort in the compare cycle discards that compare.
                    if (!abort) begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            if (!first_err_valid) begin
                                first_err_vec   <= vec;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (!last_vec)
                            vec <= vec + 1'b1;
                    end
                end
                DONE: pass <= (err_count == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_check_seq.sv
// Directed bench for gate_check_seq: two instances (SETTLE=1 and SETTLE=3)
// each driving a NOR-built OR cell model with a behavioural OR reference.
module tb_gate_check_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 1: SETTLE=1
    logic       start1 = 0, abort1 = 0;
    logic [1:0] vec1;
    logic       dut1, ref1, busy1, done1, pass1, fval1;
    logic [2:0] err1;
    logic [1:0] fev1;
    int         mode = 0;   // 0: NOR-built OR, 1: stuck-at-0, 2: plain NOR

    logic nor1;
    assign nor1 = ~(vec1[0] | vec1[1]);
    assign ref1 = vec1[0] | vec1[1];
    assign dut1 = (mode == 0) ? ~(nor1 | nor1) : (mode == 1) ? 1'b0 : nor1;

    gate_check_seq #(.N_IN(2), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec(vec1),
        .dut_s(dut1), .ref_s(ref1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_vec(fev1), .first_err_valid(fval1)
    );

    // instance 3: SETTLE=3, always-matching gate
    logic       start3 = 0, abort3 = 0;
    logic [1:0] vec3;
    logic       dut3, ref3, busy3, done3, pass3, fval3;
    logic [2:0] err3;
    logic [1:0] fev3;
    logic       nor3;
    assign nor3 = ~(vec3[0] | vec3[1]);
    assign ref3 = vec3[0] | vec3[1];
    assign dut3 = ~(nor3 | nor3);

    gate_check_seq #(.N_IN(2), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .vec(vec3),
        .dut_s(dut3), .ref_s(ref3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_err_vec(fev3), .first_err_valid(fval3)
    );

    int total = 0, bad = 0;
    int cyc;
    int d1_cyc, d1_n, d3_cyc, d3_n;
    logic [1:0] vh1 [0:63];
    logic [1:0] vh3 [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic begin_run();
        cyc = 0; d1_n = 0; d1_cyc = -1; d3_n = 0; d3_cyc = -1;
    endtask

    // One clock; sample #1 after the edge. cyc counts edges since begin_run.
    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (cyc < 64) begin
            vh1[cyc] = vec1;
            vh3[cyc] = vec3;
        end
        if (done1) begin if (d1_n == 0) d1_cyc = cyc; d1_n++; end
        if (done3) begin if (d3_n == 0) d3_cyc = cyc; d3_n++; end
    endtask

    task automatic ticks_to(input int c);
        while (cyc < c) tick();
    endtask

    // Pulse start1 so that it is sampled by the edge that begins cycle 1.
    task automatic kick1();
        begin_run();
        start1 = 1;
        tick();
        start1 = 0;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        begin_run();

        // reset state
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err",  err1,  0);
        chk("rst_vec",  vec1,  0);
        chk("rst_fval", fval1, 0);

        // basic pass, NOR-built OR
        mode = 0;
        kick1();
        ticks_to(12);
        for (int c = 1; c <= 8; c++) chk("basic_vec", vh1[c], (c - 1) / 2);
        chk("basic_done_cyc", d1_cyc, 9);
        chk("basic_done_n",   d1_n,   1);
        chk("basic_pass",     pass1,  1);
        chk("basic_err",      err1,   0);
        chk("basic_fval",     fval1,  0);
        chk("basic_vec_hold", vec1,   3);

        // stuck-at-0: vectors 01,10,11 fail
        mode = 1;
        kick1();
        ticks_to(12);
        chk("sa0_done_cyc", d1_cyc, 9);
        chk("sa0_err",      err1,   3);
        chk("sa0_fev",      fev1,   1);
        chk("sa0_fval",     fval1,  1);
        chk("sa0_pass",     pass1,  0);

        // inverted (plain NOR): every vector fails
        mode = 2;
        kick1();
        ticks_to(12);
        chk("inv_err",  err1,  4);
        chk("inv_fev",  fev1,  0);
        chk("inv_fval", fval1, 1);
        chk("inv_pass", pass1, 0);

        // restore pass=1 so the abort run must visibly clear it
        mode = 0;
        kick1();
        ticks_to(12);
        chk("pre_abort_pass", pass1, 1);

        // abort in CMP of vec 01 with stuck-at-0 DUT
        mode = 1;
        kick1();
        ticks_to(4);
        chk("abort_busy_c4", busy1, 1);
        abort1 = 1;
        tick();
        abort1 = 0;
        chk("abort_busy_c5", busy1, 0);
        chk("abort_err",     err1,  0);
        chk("abort_fval",    fval1, 0);
        chk("abort_pass",    pass1, 0);
        ticks_to(14);
        chk("abort_no_done", d1_n,  0);

        // start re-pulsed while busy is ignored
        mode = 0;
        kick1();
        ticks_to(3);
        start1 = 1;
        tick();
        start1 = 0;
        ticks_to(16);
        chk("repulse_done_cyc", d1_cyc, 9);
        chk("repulse_done_n",   d1_n,   1);
        chk("repulse_pass",     pass1,  1);
        chk("repulse_idle",     busy1,  0);

        // asynchronous reset mid-run (stuck-at-0 so err is nonzero by cycle 5)
        mode = 1;
        kick1();
        ticks_to(5);
        chk("prerst_err", err1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy1, 0);
        chk("midrst_err",  err1,  0);
        chk("midrst_vec",  vec1,  0);
        chk("midrst_fval", fval1, 0);
        chk("midrst_pass", pass1, 0);
        chk("midrst_done", done1, 0);
        #3 rst_n = 1'b1;
        mode = 0;
        kick1();
        ticks_to(12);
        chk("postrst_done_cyc", d1_cyc, 9);
        chk("postrst_pass",     pass1,  1);
        chk("postrst_err",      err1,   0);

        // simultaneous start and abort in IDLE
        begin_run();
        start1 = 1; abort1 = 1;
        tick();
        start1 = 0; abort1 = 0;
        chk("sa_busy", busy1, 0);
        ticks_to(12);
        chk("sa_no_done", d1_n, 0);

        // SETTLE=3: each vector held 4 cycles
        begin_run();
        start3 = 1;
        tick();
        start3 = 0;
        ticks_to(20);
        chk("s3_vec_c4",   vh3[4],  0);
        chk("s3_vec_c5",   vh3[5],  1);
        chk("s3_vec_c16",  vh3[16], 3);
        chk("s3_done_cyc", d3_cyc,  17);
        chk("s3_done_n",   d3_n,    1);
        chk("s3_pass",     pass3,   1);
        chk("s3_err",      err3,    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
